// File: rtl/jpeg_rle_encoder.sv
// JPEG zero-run-length / size-category encoder.
// Takes one 8x8 block of quantized coefficients in zigzag order and emits
// (run, size, amplitude) symbols: DPCM DC, AC, ZRL (15,0) and EOB (0,0).
// The output is a single registered valid/ready slot.
module jpeg_rle_encoder #(
  parameter int COEF_W = 11,
  parameter int DIFF_W = COEF_W + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [COEF_W-1:0] in_coef,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [3:0]        out_run,
  output logic [3:0]        out_size,
  output logic [DIFF_W-1:0] out_amp,
  output logic              out_is_dc,
  output logic              out_eob
);

  typedef enum logic [1:0] {S_RUN, S_ZRL, S_EOB} state_t;

  state_t            state;
  logic [5:0]        idx;
  logic [5:0]        zrun;
  logic [COEF_W-1:0] dc_pred;
  logic [COEF_W-1:0] held;
  logic              rdy_en;
  logic              slot_free;
  logic              accept;
  logic              zrl_due;

  logic [DIFF_W-1:0] coef_x, pred_x, held_x, diff, sym_v, sym_amp;
  logic [3:0]        sym_size;

  logic              ld, ld_dc, ld_eob;
  logic [3:0]        ld_run, ld_size;
  logic [DIFF_W-1:0] ld_amp;

  // Bit length of |v|; v is two's complement.
  function automatic logic [3:0] size_of(input logic [DIFF_W-1:0] v);
    logic [DIFF_W-1:0] mag;
    logic [3:0]        s;
    mag = v[DIFF_W-1] ? DIFF_W'(-v) : v;
    s   = 4'd0;
    for (int i = 0; i < DIFF_W; i++)
      if (mag[i]) s = 4'(i + 1);
    return s;
  endfunction

  // Positive values pass through; negatives become (v-1) kept to sz bits.
  function automatic logic [DIFF_W-1:0] amp_of(input logic [DIFF_W-1:0] v,
                                               input logic [3:0]        sz);
    logic [DIFF_W:0] mask;
    mask = ((DIFF_W+1)'(1) << sz) - (DIFF_W+1)'(1);
    return v[DIFF_W-1] ? ((v - DIFF_W'(1)) & mask[DIFF_W-1:0]) : v;
  endfunction

  assign coef_x    = {{(DIFF_W-COEF_W){in_coef[COEF_W-1]}}, in_coef};
  assign pred_x    = {{(DIFF_W-COEF_W){dc_pred[COEF_W-1]}}, dc_pred};
  assign held_x    = {{(DIFF_W-COEF_W){held[COEF_W-1]}}, held};
  assign diff      = coef_x - pred_x;

  // rdy_en keeps in_ready low while reset is asserted.
  assign slot_free = !out_valid || out_ready;
  assign in_ready  = rdy_en && (state == S_RUN) && slot_free;
  assign accept    = in_valid && in_ready;
  assign zrl_due   = (zrun >= 6'd16);

  // Value whose size/amplitude is encoded this cycle: latched AC in ZRL,
  // DC difference at index 0, otherwise the incoming AC.
  always_comb begin
    sym_v    = (state == S_ZRL) ? held_x : ((idx == 6'd0) ? diff : coef_x);
    sym_size = size_of(sym_v);
    sym_amp  = amp_of(sym_v, sym_size);
  end

  // Decide whether the output slot is loaded this cycle and with what.
  always_comb begin
    ld      = 1'b0;
    ld_run  = 4'd0;
    ld_size = 4'd0;
    ld_amp  = '0;
    ld_dc   = 1'b0;
    ld_eob  = 1'b0;
    case (state)
      S_RUN: begin
        if (accept) begin
          if (idx == 6'd0) begin
            ld      = 1'b1;
            ld_size = sym_size;
            ld_amp  = sym_amp;
            ld_dc   = 1'b1;
          end else if (in_coef != '0) begin
            ld = 1'b1;
            if (zrl_due) begin
              ld_run = 4'd15;
            end else begin
              ld_run  = zrun[3:0];
              ld_size = sym_size;
              ld_amp  = sym_amp;
            end
          end
        end
      end
      S_ZRL: begin
        if (slot_free) begin
          ld = 1'b1;
          if (zrl_due) begin
            ld_run = 4'd15;
          end else begin
            ld_run  = zrun[3:0];
            ld_size = sym_size;
            ld_amp  = sym_amp;
          end
        end
      end
      S_EOB: begin
        if (slot_free) begin
          ld     = 1'b1;
          ld_eob = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Block-position FSM plus the registered output slot.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_RUN;
      idx       <= 6'd0;
      zrun      <= 6'd0;
      dc_pred   <= '0;
      held      <= '0;
      rdy_en    <= 1'b0;
      out_valid <= 1'b0;
      out_run   <= 4'd0;
      out_size  <= 4'd0;
      out_amp   <= '0;
      out_is_dc <= 1'b0;
      out_eob   <= 1'b0;
    end else begin
      rdy_en <= 1'b1;

      if (ld) begin
        out_valid <= 1'b1;
        out_run   <= ld_run;
        out_size  <= ld_size;
        out_amp   <= ld_amp;
        out_is_dc <= ld_dc;
        out_eob   <= ld_eob;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end

      case (state)
        S_RUN: begin
          if (accept) begin
            idx <= idx + 6'd1;
            if (idx == 6'd0) begin
              dc_pred <= in_coef;
            end else if (in_coef == '0) begin
              // A block ending in zeros drops any pending ZRLs for one EOB.
              if (idx == 6'd63) begin
                zrun  <= 6'd0;
                state <= S_EOB;
              end else begin
                zrun <= zrun + 6'd1;
              end
            end else if (zrl_due) begin
              // First ZRL goes out now; the rest drain from S_ZRL.
              held  <= in_coef;
              zrun  <= zrun - 6'd16;
              state <= S_ZRL;
            end else begin
              zrun <= 6'd0;
            end
          end
        end
        S_ZRL: begin
          if (slot_free) begin
            if (zrl_due) begin
              zrun <= zrun - 6'd16;
            end else begin
              zrun  <= 6'd0;
              state <= S_RUN;
            end
          end
        end
        S_EOB: begin
          if (slot_free) state <= S_RUN;
        end
        default: state <= S_RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_jpeg_rle_encoder.sv
// Bench for jpeg_rle_encoder: block-level reference model feeding an
// expected-symbol queue, one negedge monitor, and literal spot checks.
module tb_jpeg_rle_encoder;
  localparam int COEF_W = 11;
  localparam int DIFF_W = COEF_W + 1;

  typedef struct packed {
    logic [3:0]        run;
    logic [3:0]        size;
    logic [DIFF_W-1:0] amp;
    logic              dc;
    logic              eob;
  } sym_t;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              in_valid;
  logic              in_ready;
  logic [COEF_W-1:0] in_coef;
  logic              out_valid;
  logic              out_ready;
  logic [3:0]        out_run;
  logic [3:0]        out_size;
  logic [DIFF_W-1:0] out_amp;
  logic              out_is_dc;
  logic              out_eob;

  jpeg_rle_encoder #(.COEF_W(COEF_W), .DIFF_W(DIFF_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_coef(in_coef),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_run(out_run), .out_size(out_size), .out_amp(out_amp),
    .out_is_dc(out_is_dc), .out_eob(out_eob)
  );

  always #5 clk = ~clk;

  int   n_chk  = 0;
  int   n_fail = 0;
  int   blk[64];
  int   mdl_pred = 0;
  bit   rand_bp  = 1'b0;
  sym_t exp_q[$];
  sym_t got_q[$];
  sym_t prev_sym;
  bit   prev_stall = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference size/amplitude from plain integer arithmetic.
  function automatic int ref_size(int v);
    int m = (v < 0) ? -v : v;
    int s = 0;
    while (m > 0) begin s++; m = m / 2; end
    return s;
  endfunction

  function automatic int ref_amp(int v);
    if (v >= 0) return v;
    return v + (1 << ref_size(v)) - 1;
  endfunction

  function automatic sym_t mk(int run, int v, bit dc, bit eob);
    sym_t s;
    s.run = 4'(run); s.size = 4'(ref_size(v)); s.amp = DIFF_W'(ref_amp(v));
    s.dc = dc; s.eob = eob;
    return s;
  endfunction

  function automatic sym_t lit(int r, int sz, int a, bit dc, bit eob);
    sym_t s;
    s.run = 4'(r); s.size = 4'(sz); s.amp = DIFF_W'(a); s.dc = dc; s.eob = eob;
    return s;
  endfunction

  // Expected symbols for the first n coefficients of blk (n==64: full block).
  task automatic model_block(input int n);
    int run = 0;
    exp_q.push_back(mk(0, blk[0] - mdl_pred, 1'b1, 1'b0));
    mdl_pred = blk[0];
    for (int k = 1; k < n; k++) begin
      if (blk[k] == 0) run++;
      else begin
        while (run >= 16) begin exp_q.push_back(mk(15, 0, 1'b0, 1'b0)); run -= 16; end
        exp_q.push_back(mk(run, blk[k], 1'b0, 1'b0));
        run = 0;
      end
    end
    if (n == 64 && blk[63] == 0) exp_q.push_back(mk(0, 0, 1'b0, 1'b1));
  endtask

  // Drive the first n coefficients of blk; entered and left at posedge+1.
  task automatic send(input int n);
    for (int i = 0; i < n; i++) begin
      int t = 0;
      bit done = 1'b0;
      in_valid = 1'b1;
      in_coef  = COEF_W'(blk[i]);
      while (!done) begin
        @(negedge clk);
        done = in_ready;
        @(posedge clk); #1;
        t++;
        if (!done && t > 300) begin
          n_chk++; n_fail++;
          $display("FAIL send_timeout: coef %0d never accepted", i);
          done = 1'b1;
        end
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int t = 0;
    while ((exp_q.size() != 0 || out_valid) && t < 3000) begin
      @(posedge clk); #1; t++;
    end
    n_chk++;
    if (t >= 3000) begin
      n_fail++;
      $display("FAIL drain_timeout: %0d symbols still expected", exp_q.size());
    end
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic run_block();
    model_block(64);
    send(64);
    drain();
  endtask

  task automatic clear_blk();
    for (int k = 0; k < 64; k++) blk[k] = 0;
  endtask

  task automatic assert_reset_and_check();
    in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_in_ready", in_ready, 1'b0);
    chk("rst_fields", {out_run, out_size, out_amp, out_is_dc, out_eob}, '0);
  endtask

  task automatic release_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_in_ready", in_ready, 1'b1);
    mdl_pred = 0;
    exp_q.delete();
  endtask

  // Backpressure generator.
  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      out_ready = rand_bp ? ($urandom_range(0, 3) != 0) : 1'b1;
    end
  end

  // Output monitor: stream order, hold-while-stalled, in_ready during ZRL.
  always @(negedge clk) begin
    sym_t cur;
    cur = {out_run, out_size, out_amp, out_is_dc, out_eob};
    if (!rst_n) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        chk("stall_valid", out_valid, 1'b1);
        chk("stall_hold", cur, prev_sym);
      end
      if (out_valid && out_run == 4'd15 && out_size == 4'd0 && !out_is_dc && !out_eob)
        chk("zrl_in_ready", in_ready, 1'b0);
      if (out_valid && out_ready) begin
        got_q.push_back(cur);
        if (exp_q.size() == 0) begin
          n_chk++; n_fail++;
          $display("FAIL stream: unexpected symbol %h", cur);
        end else begin
          chk("stream", cur, exp_q.pop_front());
        end
      end
      prev_stall = out_valid && !out_ready;
      prev_sym   = cur;
    end
  end

  initial begin
    rst_n    = 1'b1;
    in_valid = 1'b0;
    in_coef  = '0;
    #2;

    // Model pins
    chk("ref_size_1023", 64'(ref_size(1023)), 64'd10);
    chk("ref_amp_m1024", 64'(ref_amp(-1024)), 64'd1023);
    chk("ref_amp_m2047", 64'(ref_amp(-2047)), 64'd0);

    assert_reset_and_check();
    release_reset();

    // DC=+5, all AC zero, twice
    clear_blk(); blk[0] = 5; got_q.delete();
    run_block();
    chk("dc5_count", got_q.size(), 2);
    chk("dc5_sym", got_q[0], lit(0, 3, 5, 1, 0));
    chk("dc5_eob", got_q[1], lit(0, 0, 0, 0, 1));
    got_q.delete();
    run_block();
    chk("dc5_again_zero_diff", got_q[0], lit(0, 0, 0, 1, 0));
    chk("dc5_again_count", got_q.size(), 2);

    // Negative amplitudes after fresh reset
    assert_reset_and_check();
    release_reset();
    clear_blk(); blk[0] = -3; blk[1] = -1; blk[2] = 2; got_q.delete();
    run_block();
    chk("neg_count", got_q.size(), 4);
    chk("neg_dc", got_q[0], lit(0, 2, 0, 1, 0));
    chk("neg_ac1", got_q[1], lit(0, 1, 0, 0, 0));
    chk("neg_ac2", got_q[2], lit(0, 2, 2, 0, 0));
    chk("neg_eob", got_q[3], lit(0, 0, 0, 0, 1));

    // 34 zeros then 7: two ZRLs
    clear_blk(); blk[35] = 7; got_q.delete();
    run_block();
    chk("zrl2_count", got_q.size(), 5);
    chk("zrl2_z0", got_q[1], lit(15, 0, 0, 0, 0));
    chk("zrl2_z1", got_q[2], lit(15, 0, 0, 0, 0));
    chk("zrl2_sym", got_q[3], lit(2, 3, 7, 0, 0));
    chk("zrl2_eob", got_q[4], lit(0, 0, 0, 0, 1));

    // Only idx63 nonzero: three ZRLs, (14,1,1), no EOB
    clear_blk(); blk[63] = 1; got_q.delete();
    run_block();
    chk("last_count", got_q.size(), 5);
    chk("last_z2", got_q[3], lit(15, 0, 0, 0, 0));
    chk("last_sym", got_q[4], lit(14, 1, 1, 0, 0));

    // Random blocks under backpressure
    rand_bp = 1'b1;
    for (int b = 0; b < 100; b++) begin
      int dens = $urandom_range(1, 8);
      blk[0] = int'($urandom_range(0, 2047)) - 1024;
      for (int k = 1; k < 64; k++) begin
        if ($urandom_range(0, dens * 3) == 0) begin
          if ($urandom_range(0, 9) == 0)
            blk[k] = ($urandom_range(0, 1) != 0) ? 1023 : -1024;
          else
            blk[k] = ($urandom_range(0, 1) != 0) ? int'($urandom_range(1, 40))
                                                 : -int'($urandom_range(1, 40));
        end else begin
          blk[k] = 0;
        end
      end
      if ($urandom_range(0, 3) == 0) blk[63] = int'($urandom_range(1, 9));
      model_block(64);
      send(64);
    end
    drain();
    rand_bp = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Reset mid-block with a symbol in the output slot
    clear_blk(); blk[0] = 3;
    for (int k = 1; k < 10; k++) blk[k] = 2;
    blk[20] = 5;
    model_block(21);
    send(21);
    chk("mid_out_valid", out_valid, 1'b1);
    assert_reset_and_check();
    chk("mid_unconsumed", exp_q.size(), 1);
    release_reset();
    clear_blk(); blk[0] = 4; got_q.delete();
    run_block();
    chk("mid_new_dc", got_q[0], lit(0, 3, 4, 1, 0));
    chk("mid_new_count", got_q.size(), 2);

    chk("final_queue_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/jpeg_rle_encoder.md
# jpeg_rle_encoder

Zero-run-length and size-category encoder for the JPEG entropy path. Consumes one 8x8 block of quantized coefficients in zigzag order (index 0 = DC) and emits JPEG (run, size, amplitude) symbols: DPCM-coded DC, AC symbols, ZRL (15,0) and EOB (0,0). Sits between the quantizer/zigzag buffer and the Huffman coding stage; the output handshake is a registered single-entry valid/ready stage.

## Interface
- COEF_W, 11, signed width of input coefficients (two's complement)
- DIFF_W, COEF_W+1, width of DC difference and of out_amp
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  in_coef valid
- in_ready  output  1  block accepts in_coef this cycle
- in_coef  input  COEF_W  quantized coefficient, zigzag order, signed
- out_valid  output  1  symbol valid
- out_ready  input  1  downstream accepts symbol
- out_run  output  4  zero run preceding coefficient (0..15)
- out_size  output  4  size category (0..DIFF_W)
- out_amp  output  DIFF_W  amplitude bits, LSB-aligned, upper bits zero
- out_is_dc  output  1  symbol is the DC symbol of a block
- out_eob  output  1  symbol is EOB (run 0, size 0, not DC)

## Operation
- Accept when in_valid && in_ready. Internal idx (6 bit) counts accepted coefficients; wraps 63 -> 0 to start next block.
- idx 0 (DC): diff = in_coef - dc_pred (sign-extended to DIFF_W); dc_pred <= in_coef; emit run 0, size(diff), amp(diff), out_is_dc=1. Zero diff -> size 0, amp 0.
- idx 1..63, coef == 0: no emit; zrun <= zrun+1 (6 bit, max 63).
- idx 1..63, coef != 0: if zrun >= 16, enter ZRL state: emit (15,0) per 16 pending zeros, zrun -= 16 each, in_ready held low; the held coefficient is latched internally. When zrun < 16, emit (zrun, size, amp); zrun <= 0.
- idx 63 accepted with coef == 0 (i.e. block ends in zeros, including all-AC-zero): emit EOB after any pending symbol; zrun <= 0. Pending ZRLs are discarded, never emitted before EOB.
- Last coefficient nonzero: no EOB.
- size(v) = bit length of |v| (0 for v=0). amp(v) = v if v>0; (v-1) masked to size bits if v<0 (ones' complement).
- States: RUN (accept coefficients), ZRL (emit ZRLs, then the latched nonzero symbol), EOB (emit EOB, one cycle once output slot free). ZRL->RUN after latched symbol loads; EOB->RUN after EOB loads.
- in_ready = (state==RUN) && (!out_valid || out_ready).
- Output register: loads on any emit; held stable while out_valid && !out_ready; out_valid clears on out_ready with no new load.

## Timing
- Reset (async, rst_n low): out_valid 0, out_run/out_size/out_amp 0, out_is_dc 0, out_eob 0, in_ready 0 during reset then 1 first cycle after deassert; idx 0, zrun 0, dc_pred 0, state RUN. Reset mid-block discards the partial block and all pending symbols.
- Latency: symbol visible 1 cycle after accepting its coefficient.
- ZRL: each ZRL occupies one output cycle; n ZRLs + symbol take n+1 output cycles, in_ready low throughout.
- EOB: appears the cycle after idx 63 accepted; in_ready low that cycle (state EOB).
- Full throughput: 1 coefficient/cycle when out_ready=1 and no ZRL/EOB insertion.
- Simultaneous out_ready and new load: register replaced same edge, out_valid stays 1.

## Test plan
- Block DC=+5, ACs all 0, out_ready=1 -> (dc,0,3,amp 5) then EOB; exactly 2 symbols; next block DC=+5 -> diff 0, size 0.
- DC=-3 after reset, idx1=-1, idx2=2, rest 0 -> DC size 2 amp 0b00; (0,1,amp 0); (0,2,amp 0b10); EOB.
- idx1..34 zero, idx35=7, rest 0 -> two ZRL (15,0), then (2,3,7), EOB; in_ready low during ZRLs.
- idx63 = 1, all other ACs zero -> three ZRL (48 zeros), then (14,1,1), no EOB.
- Random out_ready backpressure over 100 random blocks -> symbol stream equals software reference model; outputs stable while stalled.
- Assert rst_n low mid-block (idx 20, zrun 10, out_valid=1) -> out_valid 0 immediately; next coefficient treated as DC with dc_pred 0.
